// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame controller: FSM states, framing bytes,
// opcodes and error codes.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOpc,
    StLen,
    StBase,
    StPayload,
    StChk
  } state_e;

  localparam logic [7:0] SyncByte     = 8'hA5;

  localparam logic [7:0] OpcWrWeights = 8'h01;
  localparam logic [7:0] OpcWrActs    = 8'h02;
  localparam logic [7:0] OpcStart     = 8'h03;

  localparam logic [2:0] ErrNone      = 3'd0;
  localparam logic [2:0] ErrChecksum  = 3'd1;
  localparam logic [2:0] ErrOpcLen    = 3'd2;
  localparam logic [2:0] ErrTimeout   = 3'd3;
  localparam logic [2:0] ErrBusy      = 3'd4;

  function automatic logic is_known_opc(input logic [7:0] opc);
    return (opc == OpcWrWeights) || (opc == OpcWrActs) || (opc == OpcStart);
  endfunction

endpackage

// File: rtl/uart_timeout.sv
// Inter-byte silence counter: expired is high once LIMIT-1 idle clks have elapsed
// since the last clear, so the owner acts on the LIMIT-th clk edge.
module uart_timeout #(
  parameter int unsigned LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LIMIT - 1);

  logic [CntW-1:0] r_cnt;

  // Saturates so a stalled owner never sees the count wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != CntLast)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = enable && (r_cnt == CntLast);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser between a UART receiver and the accelerator buffers: decodes
// SYNC/OPC/LEN/BASE/payload/CHK frames into buffer writes and start pulses.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ    = 50_000_000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       busy,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       start,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code
);

  localparam int unsigned TimeoutCycles = TIMEOUT_BYTES * 10 * (CLOCK_FREQ / BAUD);

  state_e     r_state, w_state_d;
  logic [7:0] r_opc, w_opc_d;
  logic [7:0] r_len, w_len_d;
  logic [7:0] r_addr, w_addr_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic [7:0] r_chk, w_chk_d;

  logic       r_wr_en, w_wr_en_d;
  logic       r_wr_sel, w_wr_sel_d;
  logic [7:0] r_wr_addr, w_wr_addr_d;
  logic [7:0] r_wr_data, w_wr_data_d;
  logic       r_start, w_start_d;
  logic       r_ok, w_ok_d;
  logic       r_err, w_err_d;
  logic [2:0] r_err_code, w_err_code_d;

  logic w_expired;
  logic w_to_clear;
  logic w_to_enable;
  logic w_chk_good;

  assign w_to_enable = (r_state != StIdle);
  assign w_to_clear  = rx_valid || (r_state == StIdle);
  assign w_chk_good  = (rx_data == r_chk);

  uart_timeout #(
    .LIMIT(TimeoutCycles)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_to_clear),
    .enable (w_to_enable),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_opc      <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_chk      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_start    <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ErrNone;
    end else begin
      r_state    <= w_state_d;
      r_opc      <= w_opc_d;
      r_len      <= w_len_d;
      r_addr     <= w_addr_d;
      r_cnt      <= w_cnt_d;
      r_chk      <= w_chk_d;
      r_wr_en    <= w_wr_en_d;
      r_wr_sel   <= w_wr_sel_d;
      r_wr_addr  <= w_wr_addr_d;
      r_wr_data  <= w_wr_data_d;
      r_start    <= w_start_d;
      r_ok       <= w_ok_d;
      r_err      <= w_err_d;
      r_err_code <= w_err_code_d;
    end
  end

  // Next state plus the frame bookkeeping (opcode, length, address, checksum).
  always_comb begin
    w_state_d = r_state;
    w_opc_d   = r_opc;
    w_len_d   = r_len;
    w_addr_d  = r_addr;
    w_cnt_d   = r_cnt;
    w_chk_d   = r_chk;
    if (rx_valid) begin
      case (r_state)
        StIdle: begin
          if (rx_data == SyncByte) w_state_d = StOpc;
        end
        StOpc: begin
          w_opc_d   = rx_data;
          w_chk_d   = rx_data;
          w_state_d = is_known_opc(rx_data) ? StLen : StIdle;
        end
        StLen: begin
          w_len_d   = rx_data;
          w_chk_d   = r_chk ^ rx_data;
          w_state_d = ((r_opc == OpcStart) && (rx_data != 8'h00)) ? StIdle : StBase;
        end
        StBase: begin
          w_addr_d  = rx_data;
          w_cnt_d   = '0;
          w_chk_d   = r_chk ^ rx_data;
          w_state_d = (r_len == 8'h00) ? StChk : StPayload;
        end
        StPayload: begin
          w_addr_d = r_addr + 8'd1;
          w_cnt_d  = r_cnt + 8'd1;
          w_chk_d  = r_chk ^ rx_data;
          if (r_cnt == (r_len - 8'd1)) w_state_d = StChk;
        end
        StChk: begin
          w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end else if (w_expired) begin
      w_state_d = StIdle;
    end
  end

  // Registered one-clk pulses and the sticky error code.
  always_comb begin
    w_wr_en_d    = 1'b0;
    w_wr_sel_d   = r_wr_sel;
    w_wr_addr_d  = r_wr_addr;
    w_wr_data_d  = r_wr_data;
    w_start_d    = 1'b0;
    w_ok_d       = 1'b0;
    w_err_d      = 1'b0;
    w_err_code_d = r_err_code;
    if (rx_valid) begin
      case (r_state)
        StOpc: begin
          if (!is_known_opc(rx_data)) begin
            w_err_d      = 1'b1;
            w_err_code_d = ErrOpcLen;
          end
        end
        StLen: begin
          if ((r_opc == OpcStart) && (rx_data != 8'h00)) begin
            w_err_d      = 1'b1;
            w_err_code_d = ErrOpcLen;
          end
        end
        StPayload: begin
          w_wr_en_d   = 1'b1;
          w_wr_sel_d  = r_opc[1];
          w_wr_addr_d = r_addr;
          w_wr_data_d = rx_data;
        end
        StChk: begin
          if (!w_chk_good) begin
            w_err_d      = 1'b1;
            w_err_code_d = ErrChecksum;
          end else if ((r_opc == OpcStart) && busy) begin
            w_err_d      = 1'b1;
            w_err_code_d = ErrBusy;
          end else begin
            w_ok_d       = 1'b1;
            w_err_code_d = ErrNone;
            w_start_d    = (r_opc == OpcStart);
          end
        end
        default: ;
      endcase
    end else if (w_expired) begin
      w_err_d      = 1'b1;
      w_err_code_d = ErrTimeout;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_sel    = r_wr_sel;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign start     = r_start;
  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus random frame
// streams, compared event-by-event (with clk stamps) against a frame-level model.
module tb_uart_frame_ctrl;

  localparam int unsigned ClkFreq = 1000;
  localparam int unsigned Baud    = 100;
  localparam int unsigned ToBytes = 2;
  localparam int unsigned T       = ToBytes * 10 * (ClkFreq / Baud);

  localparam logic [1:0] KWr = 2'd0, KStart = 2'd1, KOk = 2'd2, KErr = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        sel;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [2:0]  code;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       busy = 1'b0;
  logic       wr_en, wr_sel, start, frame_ok, frame_err;
  logic [7:0] wr_addr, wr_data;
  logic [2:0] err_code;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  uart_frame_ctrl #(
    .CLOCK_FREQ   (ClkFreq),
    .BAUD         (Baud),
    .TIMEOUT_BYTES(ToBytes)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(logic [1:0] k, logic s, logic [7:0] a, logic [7:0] d,
                                logic [2:0] code, int c);
    ev_t e;
    e.kind = k; e.sel = s; e.addr = a; e.data = d; e.code = code; e.cyc = c;
    return e;
  endfunction

  // Output monitor: every high pulse becomes one event stamped with its clk.
  always @(negedge clk) begin
    if (wr_en)     obs_q.push_back(mk_ev(KWr, wr_sel, wr_addr, wr_data, 3'd0, cyc));
    if (start)     obs_q.push_back(mk_ev(KStart, 1'b0, 8'h00, 8'h00, 3'd0, cyc));
    if (frame_ok)  obs_q.push_back(mk_ev(KOk, 1'b0, 8'h00, 8'h00, err_code, cyc));
    if (frame_err) obs_q.push_back(mk_ev(KErr, 1'b0, 8'h00, 8'h00, err_code, cyc));
  end

  // Called at a negedge; c is the stamp at which the byte's response is visible.
  task automatic send_byte(input logic [7:0] b, output int c);
    rx_data  = b;
    rx_valid = 1'b1;
    c        = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_test();
    idle(2);
    exp_q.delete();
    obs_q.delete();
  endtask

  // Sends one frame back-to-back and records the events the protocol rules predict.
  task automatic send_frame(input logic [7:0] opc, input logic [7:0] len,
                            input logic [7:0] base, input logic [7:0] pl[$],
                            input logic [7:0] flip, input logic bsy);
    int         c;
    logic [7:0] chk;
    busy = bsy;
    send_byte(8'hA5, c);
    send_byte(opc, c);
    if (!(opc inside {8'h01, 8'h02, 8'h03})) begin
      exp_q.push_back(mk_ev(KErr, 1'b0, 8'h00, 8'h00, 3'd2, c));
      return;
    end
    send_byte(len, c);
    if (opc == 8'h03 && len != 8'h00) begin
      exp_q.push_back(mk_ev(KErr, 1'b0, 8'h00, 8'h00, 3'd2, c));
      return;
    end
    send_byte(base, c);
    chk = opc ^ len ^ base;
    for (int k = 0; k < int'(len); k++) begin
      send_byte(pl[k], c);
      exp_q.push_back(mk_ev(KWr, opc[1], base + 8'(k), pl[k], 3'd0, c));
      chk = chk ^ pl[k];
    end
    send_byte(chk ^ flip, c);
    if (flip != 8'h00) begin
      exp_q.push_back(mk_ev(KErr, 1'b0, 8'h00, 8'h00, 3'd1, c));
    end else if (opc == 8'h03 && bsy) begin
      exp_q.push_back(mk_ev(KErr, 1'b0, 8'h00, 8'h00, 3'd4, c));
    end else begin
      if (opc == 8'h03) exp_q.push_back(mk_ev(KStart, 1'b0, 8'h00, 8'h00, 3'd0, c));
      exp_q.push_back(mk_ev(KOk, 1'b0, 8'h00, 8'h00, 3'd0, c));
    end
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b1;
    idle(3);
    n_cmp++;
    if ({wr_en, wr_sel, wr_addr, wr_data, start, frame_ok, frame_err, err_code} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 000000",
               {wr_en, wr_sel, wr_addr, wr_data, start, frame_ok, frame_err, err_code});
    end
    rst = 1'b0;
    begin_test();
    send_byte(8'h00, c);
    send_byte(8'h5A, c);
    idle(1);
    send_byte(8'hFF, c);
    idle(4);
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_err++;
      $display("FAIL idle_discard: got %0d events required 0", obs_q.size());
    end
  endtask

  task automatic test_weight_write();
    logic [7:0] pl[$];
    begin_test();
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    send_frame(8'h01, 8'h03, 8'h10, pl, 8'h00, 1'b0);
    idle(3);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL weight_write count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL weight_write ev%0d: got kind=%0d sel=%0d addr=%h data=%h code=%0d cyc=%0d required kind=%0d sel=%0d addr=%h data=%h code=%0d cyc=%0d",
                 i, obs_q[i].kind, obs_q[i].sel, obs_q[i].addr, obs_q[i].data, obs_q[i].code,
                 obs_q[i].cyc, exp_q[i].kind, exp_q[i].sel, exp_q[i].addr, exp_q[i].data,
                 exp_q[i].code, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] pl[$];
    begin_test();
    pl.push_back(8'hAA); pl.push_back(8'hBB);
    send_frame(8'h02, 8'h02, 8'hFF, pl, 8'h00, 1'b0);
    idle(3);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL addr_wrap count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL addr_wrap ev%0d: got kind=%0d sel=%0d addr=%h data=%h cyc=%0d required kind=%0d sel=%0d addr=%h data=%h cyc=%0d",
                 i, obs_q[i].kind, obs_q[i].sel, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                 exp_q[i].kind, exp_q[i].sel, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_start();
    logic [7:0] pl[$];
    begin_test();
    send_frame(8'h03, 8'h00, 8'h00, pl, 8'h00, 1'b0);
    idle(2);
    send_frame(8'h03, 8'h00, 8'h00, pl, 8'h00, 1'b1);
    busy = 1'b0;
    idle(5);
    n_cmp++;
    if (err_code !== 3'd4) begin
      n_err++;
      $display("FAIL start_busy_hold: got err_code=%0d required 4", err_code);
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL start count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL start ev%0d: got kind=%0d code=%0d cyc=%0d required kind=%0d code=%0d cyc=%0d",
                 i, obs_q[i].kind, obs_q[i].code, obs_q[i].cyc,
                 exp_q[i].kind, exp_q[i].code, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] pl[$];
    begin_test();
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    send_frame(8'h01, 8'h03, 8'h10, pl, 8'h01, 1'b0);
    idle(10);
    n_cmp++;
    if (err_code !== 3'd1) begin
      n_err++;
      $display("FAIL bad_chk_hold: got err_code=%0d required 1", err_code);
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL bad_chk count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bad_chk ev%0d: got kind=%0d addr=%h data=%h code=%0d cyc=%0d required kind=%0d addr=%h data=%h code=%0d cyc=%0d",
                 i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data, obs_q[i].code, obs_q[i].cyc,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data, exp_q[i].code, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_timeout();
    int         c;
    logic [7:0] pl[$];
    begin_test();
    send_byte(8'hA5, c);
    send_byte(8'h01, c);
    exp_q.push_back(mk_ev(KErr, 1'b0, 8'h00, 8'h00, 3'd3, c + int'(T)));
    idle(int'(T) + 10);
    pl.push_back(8'h5A);
    send_frame(8'h01, 8'h01, 8'h40, pl, 8'h00, 1'b0);
    idle(3);
    // A byte landing on the very clk the timeout would fire is still accepted.
    send_byte(8'hA5, c);
    send_byte(8'h01, c);
    idle(int'(T) - 1);
    send_byte(8'h00, c);
    send_byte(8'h20, c);
    send_byte(8'h21, c);
    exp_q.push_back(mk_ev(KOk, 1'b0, 8'h00, 8'h00, 3'd0, c));
    idle(4);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL timeout count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL timeout ev%0d: got kind=%0d addr=%h data=%h code=%0d cyc=%0d required kind=%0d addr=%h data=%h code=%0d cyc=%0d",
                 i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data, obs_q[i].code, obs_q[i].cyc,
                 exp_q[i].kind, exp_q[i].addr, exp_q[i].data, exp_q[i].code, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int         c;
    logic [7:0] pl[$];
    begin_test();
    send_frame(8'h77, 8'h00, 8'h00, pl, 8'h00, 1'b0);
    idle(3);
    send_byte(8'hA5, c);
    send_byte(8'h01, c);
    send_byte(8'h03, c);
    send_byte(8'h10, c);
    send_byte(8'h11, c);
    exp_q.push_back(mk_ev(KWr, 1'b0, 8'h10, 8'h11, 3'd0, c));
    send_byte(8'h22, c);
    exp_q.push_back(mk_ev(KWr, 1'b0, 8'h11, 8'h22, 3'd0, c));
    rst = 1'b1;
    idle(2);
    n_cmp++;
    if ({wr_en, wr_sel, wr_addr, wr_data, start, frame_ok, frame_err, err_code} !== 24'h0) begin
      n_err++;
      $display("FAIL midframe_reset_outputs: got %h required 000000",
               {wr_en, wr_sel, wr_addr, wr_data, start, frame_ok, frame_err, err_code});
    end
    rst = 1'b0;
    idle(2);
    pl.push_back(8'h01); pl.push_back(8'h02);
    send_frame(8'h02, 8'h02, 8'h80, pl, 8'h00, 1'b0);
    idle(3);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL midframe count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL midframe ev%0d: got kind=%0d sel=%0d addr=%h data=%h code=%0d cyc=%0d required kind=%0d sel=%0d addr=%h data=%h code=%0d cyc=%0d",
                 i, obs_q[i].kind, obs_q[i].sel, obs_q[i].addr, obs_q[i].data, obs_q[i].code,
                 obs_q[i].cyc, exp_q[i].kind, exp_q[i].sel, exp_q[i].addr, exp_q[i].data,
                 exp_q[i].code, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         c;
    int         sel;
    int         ng;
    logic [7:0] gb, opc, len, base, flip;
    logic       bsy;
    logic [7:0] pl[$];
    begin_test();
    for (int f = 0; f < 60; f++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hA5) gb = 8'h5A;
        send_byte(gb, c);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
      pl.delete();
      sel  = $urandom_range(0, 9);
      base = 8'($urandom_range(0, 255));
      bsy  = ($urandom_range(0, 1) == 1);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (sel == 0) begin
        opc = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(4, 255));
        len = 8'h00;
      end else if (sel == 1) begin
        opc = 8'h03;
        len = 8'($urandom_range(1, 255));
      end else if (sel <= 3) begin
        opc = 8'h03;
        len = 8'h00;
      end else begin
        opc = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h01;
        len = 8'($urandom_range(0, 6));
        for (int k = 0; k < int'(len); k++) pl.push_back(8'($urandom_range(0, 255)));
      end
      send_frame(opc, len, base, pl, flip, bsy);
      idle($urandom_range(0, 2));
    end
    busy = 1'b0;
    idle(4);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL random count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL random ev%0d: got kind=%0d sel=%0d addr=%h data=%h code=%0d cyc=%0d required kind=%0d sel=%0d addr=%h data=%h code=%0d cyc=%0d",
                 i, obs_q[i].kind, obs_q[i].sel, obs_q[i].addr, obs_q[i].data, obs_q[i].code,
                 obs_q[i].cyc, exp_q[i].kind, exp_q[i].sel, exp_q[i].addr, exp_q[i].data,
                 exp_q[i].code, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_weight_write();
    test_addr_wrap();
    test_start();
    test_bad_chk();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART baud rate.
REQ-003 SHALL have parameter TIMEOUT_BYTES, default 4; the inter-byte timeout is TIMEOUT_BYTES*10*(CLOCK_FREQ/BAUD) clk cycles.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx_data, input, 8, the received byte from the UART receiver.
REQ-007 SHALL have port rx_valid, input, 1, a one-clk pulse marking rx_data valid.
REQ-008 SHALL have port busy, input, 1, high while the accelerator is computing.
REQ-009 SHALL have ports wr_en (output, 1), wr_sel (output, 1: 0=weights, 1=activations), wr_addr (output, 8) and wr_data (output, 8), forming the buffer write port.
REQ-010 SHALL have port start, output, 1, a one-clk accelerator start pulse.
REQ-011 SHALL have ports frame_ok (output, 1) and frame_err (output, 1), each a one-clk frame-status pulse.
REQ-012 SHALL have port err_code, output, 3, the code of the last error, held until the next frame_err or frame_ok.

Function
REQ-013 SHALL parse frames of the form SYNC(0xA5), OPC, LEN, BASE, LEN payload bytes, CHK.
REQ-014 SHALL accept CHK only when CHK equals the XOR of OPC, LEN, BASE and all payload bytes.
REQ-015 SHALL use the FSM states IDLE, OPC, LEN, BASE, PAYLOAD, CHK; each state advances only on rx_valid.
REQ-016 SHALL, in IDLE, discard any byte other than 0xA5 with no output activity.
REQ-017 SHALL support opcodes 0x01 (write weights), 0x02 (write activations) and 0x03 (start).
REQ-018 SHALL, on any other OPC value, pulse frame_err with err_code=2 in the clk after that byte and return to IDLE.
REQ-019 SHALL, for opcode 0x03, require LEN=0; LEN not equal to 0 -> frame_err with err_code=2 and return to IDLE.
REQ-020 SHALL go from BASE directly to CHK when LEN=0.
REQ-021 SHALL, for each payload byte k (0..LEN-1), assert wr_en for exactly one clk, in the clk after its rx_valid, with wr_data=byte, wr_addr=(BASE+k) mod 256 and wr_sel=OPC[1].
REQ-022 SHALL leave payload writes already issued in place if the checksum later fails; frame_err is advisory only.
REQ-023 SHALL, on a good CHK, pulse frame_ok and clear err_code to 0 in the clk after the CHK rx_valid; for opcode 0x03 it SHALL also pulse start in that same clk.
REQ-024 SHALL, on a bad CHK, pulse frame_err with err_code=1 and never pulse start.
REQ-025 SHALL, for a good opcode-0x03 frame while busy=1 is sampled with the CHK byte, pulse frame_err with err_code=4 and suppress start.
REQ-026 SHALL count clks since the last rx_valid in every state except IDLE; reaching the timeout -> frame_err with err_code=3 and return to IDLE.
REQ-027 SHALL let rx_valid win when it occurs in the same clk the timeout count is reached: the byte is processed and the counter restarts.
REQ-028 SHALL process a 0xA5 arriving in OPC..CHK as ordinary frame data, with no resynchronisation.
REQ-029 SHALL ignore rx_valid arriving in the clk in which a frame_ok or frame_err pulse is generated, since the FSM is already in IDLE, unless that byte is 0xA5.

Reset
REQ-030 SHALL, while rst=1 at a clk edge, force state=IDLE and wr_en=start=frame_ok=frame_err=0, and clear wr_sel, wr_addr, wr_data, err_code, the checksum accumulator, the byte counter and the timeout counter to 0.
REQ-031 SHALL abandon a frame interrupted by rst mid-frame without any pulse; the first frame after reset is parsed normally.

Structure
REQ-032 SHALL define the FSM state enum, SYNC byte, opcode constants and err_code values (0 none, 1 checksum, 2 opcode/length, 3 timeout, 4 busy) in the shared package uart_pkg.
REQ-033 SHALL implement the inter-byte timeout counter as one sub-module, uart_timeout, with inputs clear and enable and output expired.

Verification
REQ-034 SHALL verify a good weight write: A5 01 03 10 11 22 33, CHK=0x01^0x03^0x10^0x11^0x22^0x33 -> writes (0x10,11), (0x11,22), (0x12,33) with wr_sel=0, then frame_ok.
REQ-035 SHALL verify address wrap: A5 02 02 FF AA BB plus correct CHK -> writes to addresses 0xFF and 0x00 with wr_sel=1, then frame_ok.
REQ-036 SHALL verify start: A5 03 00 00 03 with busy=0 -> start and frame_ok in the same clk; the same frame with busy=1 -> frame_err with err_code=4 and no start.
REQ-037 SHALL verify a bad checksum: the REQ-034 frame with CHK^0x01 -> three writes, then frame_err with err_code=1 and no start.
REQ-038 SHALL verify a timeout: A5 01 followed by silence -> frame_err with err_code=3 at exactly the timeout count after the 01 byte; a following A5 frame parses correctly.
REQ-039 SHALL verify reset mid-frame: rst after the second payload byte -> no pulses, all outputs 0; the next full frame gives frame_ok.
